// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester and
// the data (load/store) requester. Address-phase requests are arbitrated and
// the grant is held until the memory accepts the address. Each accepted
// transaction's owner goes into an in-order ID FIFO so returning data_ok/rdata
// can be steered back to the side that issued it.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration when both
// sides request together. Without it, data has fixed priority over inst.
//
// Parameters:
//   MAX_OUTST  max accepted-but-unanswered transactions (power of 2, 2..16)
//   OWW        log2(MAX_OUTST), FIFO pointer width
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_inst_*                       instruction-side request channel
//   o_inst_addr_ok/data_ok/rdata   instruction-side handshakes and read data
//   i_data_*                       data-side request channel
//   o_data_addr_ok/data_ok/rdata   data-side handshakes and read data
//   o_mem_*                        shared memory request channel
//   i_mem_addr_ok/data_ok/rdata    memory handshakes and read data
//   o_arb_busy                     at least one transaction outstanding
//   o_arb_err                      sticky: memory response with nothing outstanding
//
// Lock FSM:
//   state  | meaning
//   S_OPEN | no held grant; arbitrate fresh every cycle
//   S_LOCK | a request was presented but not accepted; grant held on r_owner
// -----------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int OWW       = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_inst_req,
    input  logic        i_inst_wr,
    input  logic [1:0]  i_inst_size,
    input  logic [3:0]  i_inst_wstrb,
    input  logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_wdata,
    output logic        o_inst_addr_ok,
    output logic        o_inst_data_ok,
    output logic [31:0] o_inst_rdata,

    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [1:0]  i_data_size,
    input  logic [3:0]  i_data_wstrb,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_data_addr_ok,
    output logic        o_data_data_ok,
    output logic [31:0] o_data_rdata,

    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [1:0]  o_mem_size,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_addr_ok,
    input  logic        i_mem_data_ok,
    input  logic [31:0] i_mem_rdata,

    output logic        o_arb_busy,
    output logic        o_arb_err
);

    localparam logic [0:0] S_OPEN = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [OWW:0] C_FULL = (OWW+1)'(MAX_OUTST);
    localparam logic [OWW:0] C_ONE  = (OWW+1)'(1);

    logic [0:0]           r_state;
    logic                 r_owner;
    logic [MAX_OUTST-1:0] r_fifo;
    logic [OWW-1:0]       r_wr_ptr;
    logic [OWW-1:0]       r_rd_ptr;
    logic [OWW:0]         r_count;
    logic                 r_err;
`ifdef ARB_RR_EN
    logic                 r_last_winner;
`endif

    logic w_gnt_vld;
    logic w_gnt_own;
    logic w_full;
    logic w_empty;
    logic w_mem_req;
    logic w_push;
    logic w_pop;
    logic w_head_own;

    // ---------------------------------------------------------------------
    // Grant selection
    // ---------------------------------------------------------------------
    // While locked the owner keeps the grant; if it has withdrawn its request
    // nobody is granted this cycle and the lock drops, so the other side is
    // picked up by a fresh arbitration on the following cycle.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_own = OWN_INST;
        if (r_state == S_LOCK) begin
            w_gnt_own = r_owner;
            w_gnt_vld = (r_owner == OWN_DATA) ? i_data_req : i_inst_req;
        end else if (i_data_req && i_inst_req) begin
            w_gnt_vld = 1'b1;
`ifdef ARB_RR_EN
            w_gnt_own = ~r_last_winner;
`else
            w_gnt_own = OWN_DATA;
`endif
        end else if (i_data_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = OWN_DATA;
        end else if (i_inst_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = OWN_INST;
        end
    end

    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    // No bypass when full: a pop this cycle only frees the slot for next cycle.
    assign w_mem_req  = w_gnt_vld && !w_full;
    assign w_push     = w_mem_req && i_mem_addr_ok;
    assign w_pop      = i_mem_data_ok && !w_empty;
    assign w_head_own = r_fifo[r_rd_ptr];

    // ---------------------------------------------------------------------
    // Address-phase outputs
    // ---------------------------------------------------------------------
    always_comb begin
        o_mem_wr    = 1'b0;
        o_mem_size  = 2'd0;
        o_mem_wstrb = 4'd0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        if (w_gnt_vld) begin
            if (w_gnt_own == OWN_DATA) begin
                o_mem_wr    = i_data_wr;
                o_mem_size  = i_data_size;
                o_mem_wstrb = i_data_wstrb;
                o_mem_addr  = i_data_addr;
                o_mem_wdata = i_data_wdata;
            end else begin
                o_mem_wr    = i_inst_wr;
                o_mem_size  = i_inst_size;
                o_mem_wstrb = i_inst_wstrb;
                o_mem_addr  = i_inst_addr;
                o_mem_wdata = i_inst_wdata;
            end
        end
    end

    assign o_mem_req      = w_mem_req;
    assign o_inst_addr_ok = w_push && (w_gnt_own == OWN_INST);
    assign o_data_addr_ok = w_push && (w_gnt_own == OWN_DATA);

    // ---------------------------------------------------------------------
    // Response routing
    // ---------------------------------------------------------------------
    assign o_inst_data_ok = w_pop && (w_head_own == OWN_INST);
    assign o_data_data_ok = w_pop && (w_head_own == OWN_DATA);
    assign o_inst_rdata   = i_mem_rdata;
    assign o_data_rdata   = i_mem_rdata;

    assign o_arb_busy = !w_empty;
    assign o_arb_err  = r_err;

    // ---------------------------------------------------------------------
    // Lock FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_OPEN;
            r_owner <= OWN_INST;
        end else begin
            case (r_state)
                S_OPEN: begin
                    if (w_mem_req && !i_mem_addr_ok) begin
                        r_state <= S_LOCK;
                        r_owner <= w_gnt_own;
                    end
                end
                S_LOCK: begin
                    // Owner accepted, or owner withdrew its request.
                    if (w_push || !w_gnt_vld) begin
                        r_state <= S_OPEN;
                    end
                end
                default: r_state <= S_OPEN;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Owner ID FIFO
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_gnt_own;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A response with nothing outstanding means the memory side and this
    // arbiter disagree; flag it until the next reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (i_mem_data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_winner <= OWN_INST;
        end else if (w_push) begin
            r_last_winner <= w_gnt_own;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        arb_busy, arb_err;

    sram_req_arbiter #(.MAX_OUTST(4), .OWW(2)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_inst_req(inst_req), .i_inst_wr(inst_wr), .i_inst_size(inst_size),
        .i_inst_wstrb(inst_wstrb), .i_inst_addr(inst_addr), .i_inst_wdata(inst_wdata),
        .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
        .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
        .i_data_wstrb(data_wstrb), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
        .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
        .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_size(mem_size),
        .o_mem_wstrb(mem_wstrb), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_addr_ok(mem_addr_ok), .i_mem_data_ok(mem_data_ok), .i_mem_rdata(mem_rdata),
        .o_arb_busy(arb_busy), .o_arb_err(arb_err)
    );

    always #5 clk = ~clk;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        owner;   // 0 = inst, 1 = data
        logic [31:0] rdata;
    } resp_t;

    resp_t q_exp[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every response the DUT presents is matched against the
    // oldest expected response queued by the stimulus.
    always @(negedge clk) begin
        if (!reset && (inst_data_ok || data_data_ok)) begin
            if (inst_data_ok && data_data_ok) begin
                chk("resp_both_sides", 32'd1, 32'd0);
            end else if (q_exp.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = q_exp.pop_front();
                chk("resp_owner", {31'd0, data_data_ok}, {31'd0, e.owner});
                chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
            end
        end
    end

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic respond(input logic owner, input logic [31:0] rd);
        mem_data_ok = 1; mem_rdata = rd;
        q_exp.push_back({owner, rd});
        smp();
        tick();
        mem_data_ok = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_own [4];
        idle_inputs();
        reset = 1;
        tick(); tick();
        smp();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_busy", {31'd0, arb_busy}, 0);
        chk("rst_err", {31'd0, arb_err}, 0);
        chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        tick();
        reset = 0;

        // ---- single inst read
        inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        smp();
        chk("t1_mem_req", {31'd0, mem_req}, 1);
        chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
        chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
        chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        smp();
        chk("t1_busy", {31'd0, arb_busy}, 1);
        tick();
        respond(1'b0, 32'h0280_0C0C);
        smp();
        chk("t1_busy_after", {31'd0, arb_busy}, 0);
        tick();

        // ---- simultaneous requests, four accepts
        for (int i = 0; i < 4; i++) exp_own[i] = RR ? ((i % 2) == 0) : 1'b1;
        inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
        mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, exp_own[i]});
            chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, !exp_own[i]});
            chk("t2_mem_addr", mem_addr, exp_own[i] ? 32'h200 : 32'h100);
            tick();
        end
        smp();
        chk("t2_full_no_req", {31'd0, mem_req}, 0);
        tick();
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        for (int i = 0; i < 4; i++) respond(exp_own[i], 32'hD000_0000 + i);

        // ---- lock: data store held while memory stalls
        data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h8;
        data_wstrb = 4'h3; data_wdata = 32'h5555_AAAA; inst_addr = 32'h40;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) inst_req = 1;
            smp();
            chk("t3_mem_addr", mem_addr, 32'h8);
            chk("t3_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
            chk("t3_mem_wr", {31'd0, mem_wr}, 1);
            chk("t3_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
            tick();
        end
        mem_addr_ok = 1;
        smp();
        chk("t3_data_addr_ok", {31'd0, data_addr_ok}, 1);
        chk("t3_inst_addr_ok4", {31'd0, inst_addr_ok}, 0);
        tick();
        data_req = 0; data_wr = 0;
        smp();
        chk("t3_inst_granted", {31'd0, inst_addr_ok}, 1);
        chk("t3_inst_addr", mem_addr, 32'h40);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        respond(1'b1, 32'h0000_0000);
        respond(1'b0, 32'h1111_2222);

        // ---- withdraw: data request dropped before acceptance
        data_req = 1; data_addr = 32'h300; inst_req = 1; inst_addr = 32'h44;
        smp();
        chk("t4_mem_addr", mem_addr, 32'h300);
        chk("t4_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
        tick();
        data_req = 0;
        tick();
        mem_addr_ok = 1;
        smp();
        chk("t4_inst_granted", {31'd0, inst_addr_ok}, 1);
        chk("t4_inst_addr", mem_addr, 32'h44);
        chk("t4_data_addr_ok", {31'd0, data_addr_ok}, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        respond(1'b0, 32'h3333_4444);
        smp();
        chk("t4_busy_after", {31'd0, arb_busy}, 0);
        tick();

        // ---- full: no bypass on the pop cycle
        inst_req = 1; inst_addr = 32'h80; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t5_fill_ok", {31'd0, inst_addr_ok}, 1);
            tick();
        end
        smp();
        chk("t5_full_mem_req", {31'd0, mem_req}, 0);
        chk("t5_full_addr_ok", {31'd0, inst_addr_ok}, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'hF000_0001;
        q_exp.push_back({1'b0, 32'hF000_0001});
        smp();
        chk("t5_pop_cycle_mem_req", {31'd0, mem_req}, 0);
        tick();
        mem_data_ok = 0;
        smp();
        chk("t5_next_mem_req", {31'd0, mem_req}, 1);
        chk("t5_next_addr_ok", {31'd0, inst_addr_ok}, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        for (int i = 0; i < 4; i++) respond(1'b0, 32'hF000_0010 + i);

        // ---- push and pop together: count holds
        inst_req = 1; inst_addr = 32'hC0; mem_addr_ok = 1;
        tick();
        mem_data_ok = 1; mem_rdata = 32'hE000_0001;
        q_exp.push_back({1'b0, 32'hE000_0001});
        smp();
        chk("t6_both_addr_ok", {31'd0, inst_addr_ok}, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        smp();
        chk("t6_busy_held", {31'd0, arb_busy}, 1);
        tick();
        respond(1'b0, 32'hE000_0002);
        smp();
        chk("t6_busy_drained", {31'd0, arb_busy}, 0);
        tick();

        // ---- reset mid-transaction, then a late response
        inst_req = 1; mem_addr_ok = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0;
        do_reset();
        smp();
        chk("t7_busy_reset", {31'd0, arb_busy}, 0);
        chk("t7_err_reset", {31'd0, arb_err}, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
        smp();
        chk("t7_spur_inst_ok", {31'd0, inst_data_ok}, 0);
        chk("t7_spur_data_ok", {31'd0, data_data_ok}, 0);
        tick();
        mem_data_ok = 0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t7_err_sticky", {31'd0, arb_err}, 1);
            tick();
        end
        do_reset();
        smp();
        chk("t7_err_cleared", {31'd0, arb_err}, 0);
        tick();

        chk("sb_drained", q_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Arbitrates address-phase requests, holds the grant stable until address acceptance, and records each accepted transaction's owner in an in-order ID FIFO.
- Routes each returning data_ok/rdata back to its owner.
- Sits between the IF/EXE stages and the AXI bridge.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions (power of 2, 2..16).
- OWW, 2, log2(MAX_OUTST); width of the FIFO pointers.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req/inst_wr  in  1/1  instruction-side request / write
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb/inst_addr/inst_wdata  in  4/32/32  instruction-side write strobe / address / write data
- inst_addr_ok/inst_data_ok  out  1/1  instruction-side address accepted / response
- inst_rdata  out  32  instruction-side read data
- data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata  in  1/1/2/4/32/32  data-side equivalents
- data_addr_ok/data_data_ok/data_rdata  out  1/1/32  data-side equivalents
- mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata  out  1/1/2/4/32/32  shared memory port
- mem_addr_ok/mem_data_ok  in  1/1  memory address accepted / response
- mem_rdata  in  32  memory read data
- arb_busy  out  1  FIFO non-empty
- arb_err  out  1  sticky: data_ok seen while FIFO empty

Behaviour:
- Synchronous active-high reset on clk. After reset:
  - FIFO empty (rd_ptr = wr_ptr = count = 0)
  - lock = 0, owner = 0
  - arb_busy = 0, arb_err = 0
  - all *_ok outputs 0; mem_req = 0 while no requester is asserting req
- Grant selection, combinational, when lock = 0:
  - data_req = 1 → grant data
  - otherwise inst_req = 1 → grant inst
  - data has fixed priority unless ARB_RR_EN is defined.
- Lock rules:
  - lock = 1, holding the owner, when mem_req = 1 && mem_addr_ok = 0.
  - While locked, the grant stays with the owner.
  - The lock clears on the owner's address acceptance.
  - The lock also clears if the owner drops req (requesters may withdraw, e.g. when MEM cannot accept). The next cycle then re-arbitrates.
- Address-phase outputs:
  - mem_req = granted_req && (count != MAX_OUTST).
  - mem_wr/size/wstrb/addr/wdata mux from the granted requester; all zero when no grant.
  - Zero-latency address phase: inst_addr_ok = mem_addr_ok && mem_req && grant==inst; data_addr_ok likewise.
  - The ungranted side always sees addr_ok = 0.
- FIFO push:
  - on mem_req && mem_addr_ok
  - writes the owner bit (0 = inst, 1 = data) at wr_ptr; wr_ptr and count advance modulo MAX_OUTST.
- FIFO pop / response routing:
  - pop on mem_data_ok && count != 0.
  - Head owner 0 → inst_data_ok = 1; head owner 1 → data_data_ok = 1.
  - inst_rdata = data_rdata = mem_rdata, pass-through. rdata is only meaningful with the matching data_ok.
  - Responses are strictly in acceptance order; writes also consume one data_ok.
- Boundaries:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full (count == MAX_OUTST): mem_req is forced 0 even if a pop occurs in the same cycle (no bypass). The request issues the next cycle.
  - mem_data_ok with count == 0: no requester data_ok, no pointer change, arb_err set until reset.
  - Reset mid-transaction: FIFO and lock are discarded; late mem_data_ok after reset follows the empty rule.
- arb_busy = (count != 0), registered view of count.

Optional Feature:
- Macro ARB_RR_EN.
- When defined:
  - A 1-bit last_winner register (reset 0 = inst) records the side of each push.
  - When both requesters are pending and unlocked, grant goes to the side that is not last_winner.
  - A requester that is alone always wins.
- When undefined: fixed data-over-inst priority, and last_winner is not implemented.

Test Plan:
- Single inst read: inst_req=1, addr=0x1C000000, mem_addr_ok=1 same cycle → inst_addr_ok=1 that cycle. Later mem_data_ok=1, mem_rdata=0x02800C0C → inst_data_ok=1, inst_rdata=0x02800C0C, data_data_ok=0.
- Simultaneous requests:
  - Stimulus: inst_req=data_req=1 for 4 accepted cycles.
  - Without ARB_RR_EN: owners D,D,D,D.
  - With ARB_RR_EN: D,I,D,I (last_winner reset 0).
  - Then four data_ok → routed in the same order.
- Lock: data store addr=0x8, wstrb=0x3, mem_addr_ok=0 for 3 cycles while inst_req rises → mem_addr stays 0x8, inst_addr_ok=0. addr_ok on cycle 4 → data_addr_ok=1. Inst is granted the next cycle.
- Withdraw: data_req high 1 cycle with addr_ok=0, then low → lock clears; pending inst_req is granted the next cycle with no FIFO push for data.
- Full: MAX_OUTST=4, four accepts without data_ok → count=4, mem_req=0 despite inst_req=1. One mem_data_ok → mem_req=1 the following cycle, not the same cycle.
- Spurious response: after reset, mem_data_ok=1 → no *_data_ok asserted, arb_err=1 held until reset.
